// File: rtl/mfcc_melbank_pkg.sv
// Shared constants and FSM encoding for the mel filterbank reader.
package mfcc_melbank_pkg;
  localparam int         NBIN     = 256;
  localparam logic [8:0] IDX_BASE = 9'd256;
  localparam logic [7:0] IDX_NONE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_W,
    ST_RD_I,
    ST_ACC,
    ST_FLUSH
  } state_t;
endpackage

// File: rtl/mfcc_melbank_acc.sv
// Falling/rising accumulator pair with bin MAC; MELBANK_SAT_EN selects saturating adds.
module mfcc_melbank_acc #(
  parameter int PWR_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             shift,
  input  logic             add_a,
  input  logic             add_b,
  input  logic [PWR_W-1:0] pwr,
  input  logic [7:0]       w,
  output logic [ACC_W-1:0] acc_a,
  output logic [ACC_W-1:0] acc_b
);
  localparam int PROD_W = PWR_W + 9;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic [PROD_W-1:0] prod_rise, prod_fall;
  logic [ACC_W-1:0]  base_a, base_b;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(p);
`ifdef MELBANK_SAT_EN
    if (s > SUM_W'({ACC_W{1'b1}})) return '1;
    return s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  always_comb begin
    prod_rise = PROD_W'(pwr) * PROD_W'(w);
    prod_fall = PROD_W'(pwr) * PROD_W'(9'd256 - {1'b0, w});
    // On a filter step the rising accumulator becomes the falling one
    base_a    = shift ? acc_b : acc_a;
    base_b    = shift ? '0 : acc_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a <= '0;
      acc_b <= '0;
    end else if (clr) begin
      acc_a <= '0;
      acc_b <= '0;
    end else if (en) begin
      acc_a <= add_a ? acc_add(base_a, prod_fall) : base_a;
      acc_b <= add_b ? acc_add(base_b, prod_rise) : base_b;
    end
  end
endmodule

// File: rtl/mfcc_melbank_reader.sv
// Mel filterbank engine: per bin reads weight then filter index from ROM, emits one energy per filter.
// Build option MELBANK_SAT_EN makes the accumulators saturate instead of wrap.
module mfcc_melbank_reader #(
  parameter int NBIN  = 256,
  parameter int NFILT = 26,
  parameter int PWR_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PWR_W-1:0] in_data,
  input  logic             in_last,
  output logic [8:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             err
);
  import mfcc_melbank_pkg::*;

  state_t           state;
  logic [7:0]       k, cur;
  logic [5:0]       ecnt;
  logic [PWR_W-1:0] pwr_p0;
  logic             last_p0;
  logic [7:0]       w_p1;

  logic [7:0]       idx;
  logic [8:0]       cur9, ecnt9;
  logic             is_none, hit, step, take, bad, need_emit, stall;
  logic             frame_end, frame_bad, add_a, add_b, acc_en, acc_clr;
  logic [ACC_W-1:0] acc_a, acc_b, fl_data;

  always_comb begin
    idx       = rom_data;
    cur9      = {1'b0, cur};
    ecnt9     = 9'(ecnt);
    is_none   = (idx == IDX_NONE);
    hit       = !is_none && (idx == cur);
    step      = !is_none && ({1'b0, idx} == cur9 + 9'd1);
    take      = hit || step;
    bad       = !is_none && !take;
    // Stepping past filter cur-1 emits it, unless it is -1 or beyond the bank
    need_emit = step && (cur != 8'd0) && (cur9 <= 9'(NFILT));
    stall     = need_emit && out_valid;
    frame_end = last_p0 || (k == 8'(NBIN-1));
    frame_bad = last_p0 != (k == 8'(NBIN-1));
    add_a     = (idx != 8'd0);
    add_b     = ({1'b0, idx} < 9'(NFILT));
    acc_en    = (state == ST_ACC) && take && !stall;
    acc_clr   = (state == ST_FLUSH) && !out_valid && (ecnt == 6'(NFILT));
    if (ecnt9 + 9'd1 == cur9)  fl_data = acc_a;
    else if (ecnt9 == cur9)    fl_data = acc_b;
    else                       fl_data = '0;
  end

  mfcc_melbank_acc #(
    .PWR_W (PWR_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .shift (step),
    .add_a (add_a),
    .add_b (add_b),
    .pwr   (pwr_p0),
    .w     (w_p1),
    .acc_a (acc_a),
    .acc_b (acc_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      k         <= '0;
      cur       <= '0;
      ecnt      <= '0;
      pwr_p0    <= '0;
      last_p0   <= 1'b0;
      w_p1      <= '0;
    end else begin
      err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        // p0: accept the bin while the weight address is presented
        ST_IDLE: begin
          rom_addr <= {1'b0, k};
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            pwr_p0   <= in_data;
            last_p0  <= in_last;
            in_ready <= 1'b0;
            state    <= ST_RD_W;
          end
        end
        ST_RD_W: begin
          rom_addr <= IDX_BASE + {1'b0, k};
          state    <= ST_RD_I;
        end
        // p1: weight arrives one cycle after its address
        ST_RD_I: begin
          w_p1  <= rom_data;
          state <= ST_ACC;
        end
        // p2: index arrives; rom_addr is held so it stays valid while stalled
        ST_ACC: begin
          if (!stall) begin
            if (bad || frame_bad) err <= 1'b1;
            if (step) cur <= idx;
            if (need_emit) begin
              out_valid <= 1'b1;
              out_data  <= acc_a;
              out_idx   <= ecnt[4:0];
              out_last  <= (ecnt == 6'(NFILT-1));
              ecnt      <= ecnt + 6'd1;
            end
            if (frame_end) begin
              k     <= '0;
              state <= ST_FLUSH;
            end else begin
              k        <= k + 8'd1;
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (!out_valid) begin
            if (ecnt == 6'(NFILT)) begin
              cur      <= '0;
              ecnt     <= '0;
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              out_valid <= 1'b1;
              out_data  <= fl_data;
              out_idx   <= ecnt[4:0];
              out_last  <= (ecnt == 6'(NFILT-1));
              ecnt      <= ecnt + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mfcc_melbank_reader.sv
// Scoreboard bench for mfcc_melbank_reader: ROM model, per-frame reference energies, err pulse counting.
`timescale 1ns/1ps
module tb_mfcc_melbank_reader;
  localparam int NBIN  = 256;
  localparam int NFILT = 26;
  localparam int PWR_W = 32;
  localparam int ACC_W = 40;

  logic             clk_tb = 1'b0;
  logic             tb_rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PWR_W-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [8:0]       rom_addr;
  logic [7:0]       rom_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [4:0]       out_idx;
  logic             out_last;
  logic             err;

  logic             stall_en = 1'b0;
  assign out_ready = !stall_en;

  mfcc_melbank_reader #(
    .NBIN  (NBIN),
    .NFILT (NFILT),
    .PWR_W (PWR_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk_tb),
    .rst_n     (tb_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk_tb = ~clk_tb;

  logic [7:0]       rom [0:511];
  logic [PWR_W-1:0] pwr [0:NBIN-1];
  always @(posedge clk_tb) rom_data <= rom[rom_addr];

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [4:0]       idx;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk_tb) begin
    exp_t e;
    if (tb_rst && err) err_seen++;
    if (tb_rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_idx), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_idx", 64'(out_idx), 64'(e.idx));
        chk("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  // Reference: energy[f] = sum of P*w over accepted bins with i==f plus P*(256-w) with i==f+1
  task automatic build_exp(input int nb, input bit has_last, output int errs);
    longint unsigned tot [256];
    longint unsigned maxv, v;
    int cur, i;
    exp_t e;
    maxv = (64'd1 << ACC_W) - 1;
    for (int f = 0; f < 256; f++) tot[f] = 0;
    cur = 0;
    errs = 0;
    for (int b = 0; b < nb; b++) begin
      i = int'(rom[256 + b]);
      if (i == 255) continue;
      if (i == cur || i == cur + 1) begin
        cur = i;
        if (i < NFILT) tot[i] += longint'(pwr[b]) * longint'(rom[b]);
        if (i >= 1) tot[i-1] += longint'(pwr[b]) * longint'(256 - int'(rom[b]));
      end else begin
        errs++;
      end
    end
    if (has_last != (nb == NBIN)) errs++;
    for (int f = 0; f < NFILT; f++) begin
`ifdef MELBANK_SAT_EN
      v = (tot[f] > maxv) ? maxv : tot[f];
`else
      v = tot[f] & maxv;
`endif
      e.data = v[ACC_W-1:0];
      e.idx  = 5'(f);
      e.last = (f == NFILT - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input int nb, input bit has_last);
    int t;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      in_valid = 1'b1;
      in_data  = pwr[b];
      in_last  = has_last && (b == nb - 1);
      while (!in_ready && t < 2000) begin
        @(negedge clk_tb);
        t++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 64'(b), 64'hFFFF);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk_tb);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int err_base, input int errs);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 4000) begin
      @(negedge clk_tb);
      t++;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk_tb);
      t++;
    end
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_err"}, 64'(err_seen - err_base), 64'(errs));
  endtask

  task automatic table_base();
    for (int k = 0; k < NBIN; k++) begin
      rom[k]       = 8'd128;
      rom[256 + k] = (k / 10 > 26) ? 8'd26 : 8'(k / 10);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int errs, base, t, unstable;
    logic [ACC_W-1:0] held;

    table_base();
    for (int k = 0; k < NBIN; k++) pwr[k] = 32'd256;
    #1 tb_rst = 1'b0;
    repeat (3) @(negedge clk_tb);
    check_reset_outputs("rst0");
    tb_rst = 1'b1;
    @(negedge clk_tb);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Frame 1: uniform table, output stalled at the first emit
    build_exp(NBIN, 1'b1, errs);
    base = err_seen;
    stall_en = 1'b1;
    fork
      send_frame(NBIN, 1'b1);
      begin
        t = 0;
        while (!out_valid && t < 5000) begin
          @(negedge clk_tb);
          t++;
        end
        chk("stall_first_valid", 64'(out_valid), 64'd1);
        held = out_data;
        unstable = 0;
        repeat (50) begin
          @(negedge clk_tb);
          if (out_data !== held || !out_valid) unstable++;
        end
        chk("stall_stable", 64'(unstable), 64'd0);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk_tb);
        #1 stall_en = 1'b0;
      end
    join
    finish_frame("uniform", base, errs);

    // Frame 2: random weights and powers, index jumps 3 -> 5 at bin 40
    for (int k = 0; k < NBIN; k++) begin
      rom[k] = 8'($urandom_range(0, 255));
      pwr[k] = $urandom_range(0, 32'h00FF_FFFF);
    end
    rom[256 + 40] = 8'd5;
    build_exp(NBIN, 1'b1, errs);
    chk("jump_model_err", 64'(errs), 64'd1);
    base = err_seen;
    send_frame(NBIN, 1'b1);
    finish_frame("jump", base, errs);

    // Frame 3: early in_last at bin 100
    table_base();
    for (int k = 0; k < NBIN; k++) pwr[k] = $urandom_range(0, 32'h000F_FFFF);
    build_exp(101, 1'b1, errs);
    base = err_seen;
    send_frame(101, 1'b1);
    finish_frame("early_last", base, errs);

    // Frame 4: full-scale power into filter 0, missing in_last at the final bin
    for (int k = 0; k < NBIN; k++) begin
      rom[k]       = 8'd255;
      rom[256 + k] = 8'hFF;
      pwr[k]       = 32'hFFFF_FFFF;
    end
    rom[256 + 0] = 8'd0;
    rom[256 + 1] = 8'd0;
    rom[256 + 2] = 8'd1;
    build_exp(NBIN, 1'b0, errs);
    base = err_seen;
    send_frame(NBIN, 1'b0);
    finish_frame("overflow", base, errs);

    // Frame 5: reset after bin 119, then a clean frame
    table_base();
    for (int k = 0; k < NBIN; k++) pwr[k] = $urandom_range(0, 32'h0000_FFFF);
    build_exp(NBIN, 1'b1, errs);
    send_frame(120, 1'b0);
    tb_rst = 1'b0;
    repeat (2) @(negedge clk_tb);
    check_reset_outputs("rst_mid");
    sb.delete();
    tb_rst = 1'b1;
    @(negedge clk_tb);
    build_exp(NBIN, 1'b1, errs);
    base = err_seen;
    send_frame(NBIN, 1'b1);
    finish_frame("after_rst", base, errs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
